// File: rtl/nibble_serial_adder_if.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder_if
// Brief    : Start/done handshake plus operand and result bus for the
//            nibble-serial wide adder.
// Revision : 1.0 - initial release
// ============================================================================
interface nibble_serial_adder_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    // Requester side: issues operands and start, observes the result.
    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    // Adder side: accepts operands, produces the result and status.
    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface
`default_nettype wire

// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder
// Brief    : Multi-cycle 4*NIBBLES-bit adder. One 4-bit ripple-carry slice is
//            reused once per clock, LSB nibble first, with the inter-nibble
//            carry held in a register. Start/done handshake.
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// RippleCarryAdder: plain 4-bit ripple-carry adder, purely combinational.
// ----------------------------------------------------------------------------
module RippleCarryAdder (
    input  wire logic [3:0] A,
    input  wire logic [3:0] B,
    input  wire logic       Cin,
    output logic      [3:0] Sum,
    output logic            Cout
);
    logic w_c;

    // Ripple the carry bit by bit through four full-adder cells.
    always_comb begin
        w_c = Cin;
        Sum = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            Sum[i] = A[i] ^ B[i] ^ w_c;
            w_c    = (A[i] & B[i]) | (w_c & (A[i] ^ B[i]));
        end
        Cout = w_c;
    end
endmodule

// ----------------------------------------------------------------------------
// nibble_serial_adder: top level sequencer around one RippleCarryAdder.
// ----------------------------------------------------------------------------
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    nibble_serial_adder_if.slave   bus
);
    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = $clog2(NIBBLES);
    // Bit offset of a nibble is idx*4, so it needs two more bits than idx.
    localparam int LOW  = IDXW + 2;

    localparam logic [IDXW-1:0] c_last_idx = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_carry;
    logic [IDXW-1:0] r_idx;
    logic [W-1:0]    r_sum;
    logic            r_cout;

    logic [LOW-1:0]  w_lo;
    logic            w_last;
    logic [3:0]      w_add_a;
    logic [3:0]      w_add_b;
    logic [3:0]      w_add_sum;
    logic            w_add_cout;

    // Nibble currently being processed and whether it is the final one.
    assign w_lo    = {r_idx, 2'b00};
    assign w_last  = (r_idx == c_last_idx);

    // Feed the selected operand nibbles and the running carry to the slice.
    assign w_add_a = r_a[w_lo +: 4];
    assign w_add_b = r_b[w_lo +: 4];

    RippleCarryAdder u_rca (
        .A    (w_add_a),
        .B    (w_add_b),
        .Cin  (r_carry),
        .Sum  (w_add_sum),
        .Cout (w_add_cout)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: start is only looked at in IDLE; DONE lasts one cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (bus.start) w_next = S_RUN;
            S_RUN:  if (w_last)    w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: latch operands on accept, then write one sum nibble per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_carry <= bus.cin;
                        r_idx   <= '0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_sum[w_lo +: 4] <= w_add_sum;
                    r_carry          <= w_add_cout;
                    if (w_last) begin
                        r_cout <= w_add_cout;
                    end else begin
                        r_idx  <= r_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Status and result outputs come straight from registers.
    assign bus.busy = (r_state != S_IDLE);
    assign bus.done = (r_state == S_DONE);
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
endmodule
`default_nettype wire
